// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_LATENCY = 4;
  localparam int DATA_W      = 32;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, combinational read of the same index.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Storage update; contents are deliberately never reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
  end

  assign rdata = mem_r[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder that stalls the pipeline for LATENCY cycles per access.
// Optional misaligned-access checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o
);

  // The accepting IDLE cycle is the first stall cycle, so BUSY only covers the remaining LATENCY-1.
  localparam int              CNT_W     = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam bit              SKIP_BUSY = (LATENCY == 1);

  dmem_state_e       state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              op_wr_r;
  logic              mis_r;
  logic [ADDR_W-1:0] idx_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;

  logic              req_s;
  logic              accept_s;
  logic              stall_s;
  logic              do_acc_s;
  logic              acc_wr_s;
  logic              acc_mis_s;
  logic              mis_in_s;
  logic [ADDR_W-1:0] acc_idx_s;
  logic [31:0]       acc_wdata_s;
  logic              we_s;
  logic [31:0]       mem_rdata_s;
  logic              unused_addr_s;

  assign req_s    = MemRead_i | MemWrite_i;
  assign accept_s = (state_r == IDLE) && req_s;

`ifdef DMEM_MISALIGN_CHK_EN
  assign mis_in_s = is_misaligned(addr_i[1:0]);
`else
  assign mis_in_s = 1'b0;
`endif

  assign unused_addr_s = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  // Next-state, stall and access-strobe decode.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    stall_s  = 1'b0;
    do_acc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          stall_s = 1'b1;
          cnt_s   = CNT_LOAD;
          if (SKIP_BUSY) begin
            do_acc_s = 1'b1;
            state_s  = DONE;
          end else begin
            state_s  = BUSY;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          do_acc_s = 1'b1;
          state_s  = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // In IDLE the live request drives the access (single-cycle case); otherwise the captured one.
  always_comb begin
    acc_wr_s    = op_wr_r;
    acc_mis_s   = mis_r;
    acc_idx_s   = idx_r;
    acc_wdata_s = wdata_r;
    if (state_r == IDLE) begin
      acc_wr_s    = MemWrite_i;
      acc_mis_s   = mis_in_s;
      acc_idx_s   = addr_i[ADDR_W+1:2];
      acc_wdata_s = wdata_i;
    end else begin
      acc_wr_s    = op_wr_r;
    end
  end

  assign we_s = do_acc_s & acc_wr_s & ~acc_mis_s;

  // FSM, counter and request capture registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      op_wr_r <= 1'b0;
      mis_r   <= 1'b0;
      idx_r   <= {ADDR_W{1'b0}};
      wdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        op_wr_r <= MemWrite_i;
        mis_r   <= mis_in_s;
        idx_r   <= addr_i[ADDR_W+1:2];
        wdata_r <= wdata_i;
      end
    end
  end

  // Load data only changes on a completed read; a flagged misaligned read returns zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_r <= 32'h0000_0000;
    end else if (do_acc_s && !acc_wr_s) begin
      rdata_r <= acc_mis_s ? 32'h0000_0000 : mem_rdata_s;
    end
  end

`ifdef DMEM_MISALIGN_CHK_EN
  logic err_r;

  // Error pulse lands in the DONE cycle following a misaligned access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= do_acc_s & acc_mis_s;
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

  assign rdata_o = rdata_r;
  assign stall_o = stall_s;

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i (clk_i),
    .we    (we_s),
    .idx   (acc_idx_s),
    .wdata (acc_wdata_s),
    .rdata (mem_rdata_s)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=4 instance driven from a vector table, LATENCY=1 instance for back-to-back loads.
module tb_dmem_responder;

  logic        clk;
  logic        rst4, rd4, wr4, stall4, err4;
  logic [31:0] addr4, wdata4, rdata4;
  logic        rst1, rd1, wr1, stall1, err1;
  logic [31:0] addr1, wdata1, rdata1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dmem_responder #(.ADDR_W(10), .LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .MemRead_i(rd4), .MemWrite_i(wr4),
    .addr_i(addr4), .wdata_i(wdata4), .rdata_o(rdata4), .stall_o(stall4), .err_o(err4)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(addr1), .wdata_i(wdata1), .rdata_o(rdata1), .stall_o(stall1), .err_o(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Drive one request, count stall cycles until DONE, sample outputs in DONE; inputs stay up through DONE.
  task automatic run_acc(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output logic [31:0] rdv, output logic errv);
    logic s;
    @(posedge clk); #1;
    if (sel) begin rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d; end
    else     begin rd4 = rd; wr4 = wr; addr4 = a; wdata4 = d; end
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s = sel ? stall1 : stall4;
      if (s === 1'b1) stalls++;
      else break;
    end
    rdv  = sel ? rdata1 : rdata4;
    errv = sel ? err1 : err4;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    rd4 = 1'b0; wr4 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
  endtask

  task automatic acc_chk(input string name, input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input int exp_stall, input logic [31:0] exp_rdata, input logic exp_err);
    int st; logic [31:0] rv; logic ev;
    run_acc(sel, rd, wr, a, d, st, rv, ev);
    chk({name, "_stall"}, 32'(st), 32'(exp_stall));
    chk({name, "_rdata"}, rv, exp_rdata);
    chk({name, "_err"}, {31'd0, ev}, {31'd0, exp_err});
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 4, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0005, 4, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 4, 32'h0000_0005, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0077, 4, 32'h0000_0005, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 4, 32'h0000_0077, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_000C, 32'h1234_5678, 4, 32'h0000_0077, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4, 32'h0000_0077, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0000_0000, 4, 32'hCAFE_F00D, 1'b0};

    rst4 = 1'b1; rd4 = 1'b0; wr4 = 1'b0; addr4 = 32'h0; wdata4 = 32'h0;
    rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    repeat (2) @(negedge clk);
    rst4 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("reset_stall", {31'd0, stall4}, 32'd0);
    chk("reset_rdata", rdata4, 32'h0);
    chk("reset_err", {31'd0, err4}, 32'd0);
    chk("reset_rdata_l1", rdata1, 32'h0);
    @(negedge clk);
    chk("idle_no_stall", {31'd0, stall4}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      acc_chk($sformatf("vec%0d", i), 1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr,
              vecs[i].wdata, vecs[i].stall, vecs[i].rdata, vecs[i].err);
    end
    go_idle();

    // Abort a store of 0x1 to 0xC while BUSY; the old value must survive.
    @(posedge clk); #1;
    wr4 = 1'b1; rd4 = 1'b0; addr4 = 32'h0000_000C; wdata4 = 32'h0000_0001;
    @(posedge clk); @(posedge clk); #2;
    chk("busy_stall", {31'd0, stall4}, 32'd1);
    rst4 = 1'b1; wr4 = 1'b0;
    #1;
    chk("rst_stall_drop", {31'd0, stall4}, 32'd0);
    chk("rst_rdata", rdata4, 32'h0);
    @(negedge clk); @(negedge clk);
    rst4 = 1'b0;
    acc_chk("after_abort", 1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 4, 32'h1234_5678, 1'b0);
    go_idle();

`ifdef DMEM_MISALIGN_CHK_EN
    acc_chk("mis_store", 1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h0000_0BAD, 4, 32'h1234_5678, 1'b1);
    acc_chk("mis_chk40", 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4, 32'hDEAD_BEEF, 1'b0);
    acc_chk("mis_load", 1'b0, 1'b1, 1'b0, 32'h0000_0041, 32'h0, 4, 32'h0000_0000, 1'b1);
`else
    acc_chk("mis_store", 1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h0000_0BAD, 4, 32'h1234_5678, 1'b0);
    acc_chk("mis_chk40", 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4, 32'h0000_0BAD, 1'b0);
    acc_chk("mis_load", 1'b0, 1'b1, 1'b0, 32'h0000_0041, 32'h0, 4, 32'h0000_0BAD, 1'b0);
`endif
    @(posedge clk); #1;
    chk("err_one_cycle", {31'd0, err4}, 32'd0);
    go_idle();

    // LATENCY=1: seed two words, then back-to-back loads with no idle gap.
    acc_chk("l1_st0", 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0011, 1, 32'h0000_0000, 1'b0);
    acc_chk("l1_st4", 1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0022, 1, 32'h0000_0000, 1'b0);
    acc_chk("l1_ld0", 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1, 32'h0000_0011, 1'b0);
    acc_chk("l1_ld4", 1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1, 32'h0000_0022, 1'b0);
    go_idle();
    @(negedge clk);
    chk("l1_idle_after", {31'd0, stall1}, 32'd0);
    chk("l1_rdata_hold", rdata1, 32'h0000_0022);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
